// File: rtl/lms_orca_spi_slave_if.sv
// CPU-side register port of the SPI slave: Avalon-style strobes, read/write data and status outputs.
interface lms_orca_spi_slave_if;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        dataavailable;
    logic        readyfordata;

    modport master (
        output spi_select, mem_addr, read_n, write_n, data_from_cpu,
        input  data_to_cpu, irq, dataavailable, readyfordata
    );

    modport slave (
        input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
        output data_to_cpu, irq, dataavailable, readyfordata
    );
endinterface

// File: rtl/lms_orca_spi_slave.sv
// SPI mode-0 slave, MSB first, SCLK/SS_n/MOSI oversampled in clk; bytes exchanged through a register port.
// MISO moves SYNC_STAGES+1 clk after a raw SCLK fall; register accesses take effect the cycle after the strobe.
module lms_orca_spi_slave #(
    parameter int                  DATABITS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [DATABITS-1:0] TXFILL      = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic SCLK,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_oe,
    lms_orca_spi_slave_if.slave bus
);

    localparam logic [2:0] LAST_BIT = 3'(DATABITS - 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic                   r_sclk_d, r_ss_d, r_armed;

    logic [2:0]             r_bitcnt;
    logic [DATABITS-1:0]    r_rx_shift, r_rx_holding, r_tx_shift, r_tx_holding;
    logic                   r_tx_primed, r_rrdy, r_roe, r_tue, r_abt;
    logic [5:0]             r_ctrl;

    logic                   r_rd_lvl, r_wr_lvl, r_rd_stb, r_wr_stb;
    logic [2:0]             r_addr;
    logic [15:0]            r_wdata, r_data_to_cpu;
    logic                   r_irq;

    logic w_sclk_s, w_ss_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_active;
    logic w_tx_load, w_frame_done;
    logic w_rd_rx, w_wr_tx, w_wr_stat, w_wr_ctrl;
    logic [DATABITS-1:0] w_rx_byte, w_tx_next;
    logic [15:0] w_status, w_rd_mux;
    logic w_rd_now, w_wr_now;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // SPI activity is only honoured once SS_n has been seen high after reset.
    assign w_active    = r_armed & ~w_ss_s;
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ss_fall   = r_armed & r_ss_d & ~w_ss_s;
    assign w_ss_rise   = r_armed & ~r_ss_d & w_ss_s;

    assign w_tx_load    = w_ss_fall | (w_active & w_sclk_fall & (r_bitcnt == 3'd0));
    assign w_frame_done = w_active & w_sclk_rise & (r_bitcnt == LAST_BIT);
    assign w_rx_byte    = {r_rx_shift[DATABITS-2:0], w_mosi_s};
    assign w_tx_next    = r_tx_primed ? r_tx_holding : TXFILL;

    assign w_rd_now  = bus.spi_select & ~bus.read_n;
    assign w_wr_now  = bus.spi_select & ~bus.write_n;
    assign w_rd_rx   = r_rd_stb & (r_addr == 3'd0);
    assign w_wr_tx   = r_wr_stb & (r_addr == 3'd1);
    assign w_wr_stat = r_wr_stb & (r_addr == 3'd2);
    assign w_wr_ctrl = r_wr_stb & (r_addr == 3'd3);

    assign w_status = {6'b0, w_active, r_roe | r_tue | r_abt, r_rrdy, ~r_tx_primed,
                       r_abt, r_tue, r_roe, 3'b0};

    always_comb begin
        w_rd_mux = 16'h0000;
        case (r_addr)
            3'd0:    w_rd_mux = {{(16-DATABITS){1'b0}}, r_rx_holding};
            3'd2:    w_rd_mux = w_status;
            3'd3:    w_rd_mux = {7'b0, r_ctrl, 3'b0};
            default: w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_sclk_s;
            r_ss_d      <= w_ss_s;
            r_armed     <= r_armed | w_ss_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_lvl <= 1'b0;
            r_wr_lvl <= 1'b0;
            r_rd_stb <= 1'b0;
            r_wr_stb <= 1'b0;
            r_addr   <= 3'd0;
            r_wdata  <= 16'h0000;
        end else begin
            r_rd_lvl <= w_rd_now;
            r_wr_lvl <= w_wr_now;
            r_rd_stb <= w_rd_now & ~r_rd_lvl;
            r_wr_stb <= w_wr_now & ~r_wr_lvl;
            if ((w_rd_now & ~r_rd_lvl) | (w_wr_now & ~r_wr_lvl)) begin
                r_addr  <= bus.mem_addr;
                r_wdata <= bus.data_from_cpu;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt      <= 3'd0;
            r_rx_shift    <= '0;
            r_rx_holding  <= '0;
            r_tx_shift    <= '0;
            r_tx_holding  <= '0;
            r_tx_primed   <= 1'b0;
            r_rrdy        <= 1'b0;
            r_roe         <= 1'b0;
            r_tue         <= 1'b0;
            r_abt         <= 1'b0;
            r_ctrl        <= 6'd0;
            r_data_to_cpu <= 16'h0000;
            r_irq         <= 1'b0;
        end else begin
            if (!w_active)
                r_bitcnt <= 3'd0;
            else if (w_sclk_rise)
                r_bitcnt <= r_bitcnt + 3'd1;

            if (w_active && w_sclk_rise)
                r_rx_shift <= w_rx_byte;
            if (w_frame_done)
                r_rx_holding <= w_rx_byte;

            if (w_tx_load)
                r_tx_shift <= w_tx_next;
            else if (w_active && w_sclk_fall)
                r_tx_shift <= {r_tx_shift[DATABITS-2:0], 1'b0};

            // A load and an accepted write in the same cycle: the load sees the old state, the new byte stays primed.
            if (w_wr_tx && !r_tx_primed) begin
                r_tx_holding <= r_wdata[DATABITS-1:0];
                r_tx_primed  <= 1'b1;
            end else if (w_tx_load) begin
                r_tx_primed  <= 1'b0;
            end

            if (w_frame_done)
                r_rrdy <= 1'b1;
            else if (w_rd_rx || w_wr_stat)
                r_rrdy <= 1'b0;

            if (w_frame_done && r_rrdy && !w_rd_rx)
                r_roe <= 1'b1;
            else if (w_wr_stat)
                r_roe <= 1'b0;

            if ((w_tx_load && !r_tx_primed) || (w_wr_tx && r_tx_primed))
                r_tue <= 1'b1;
            else if (w_wr_stat)
                r_tue <= 1'b0;

            if (w_ss_rise && (r_bitcnt != 3'd0))
                r_abt <= 1'b1;
            else if (w_wr_stat)
                r_abt <= 1'b0;

            if (w_wr_ctrl)
                r_ctrl <= r_wdata[8:3];
            if (r_rd_stb)
                r_data_to_cpu <= w_rd_mux;

            r_irq <= |(w_status[8:3] & r_ctrl);
        end
    end

    assign MISO              = r_tx_shift[DATABITS-1];
    assign MISO_oe           = w_active;
    assign bus.data_to_cpu   = r_data_to_cpu;
    assign bus.irq           = r_irq;
    assign bus.dataavailable = r_rrdy;
    assign bus.readyfordata  = ~r_tx_primed;

endmodule

// File: tb/tb_lms_orca_spi_slave.sv
// Bench for lms_orca_spi_slave: bit-banged mode-0 master plus CPU register accesses,
// with a reference model of the TX queue and status flags and scoreboards for RX and MISO bytes.
module tb_lms_orca_spi_slave;

    localparam logic [7:0] FILL = 8'h00;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
    logic MISO, MISO_oe;

    lms_orca_spi_slave_if bus();

    lms_orca_spi_slave dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic       m_primed = 1'b0, m_rrdy = 1'b0, m_roe = 1'b0, m_tue = 1'b0, m_abt = 1'b0;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] mosi_q[$];
    logic [7:0] txq[$];

    logic       da_q = 1'b0, cap_next = 1'b0;
    logic [1:0] irq_at_da = 2'b10, irq_after = 2'b10;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (bus.dataavailable && !da_q) begin
            irq_at_da = {1'b0, bus.irq};
            cap_next  = 1'b1;
        end else if (cap_next) begin
            irq_after = {1'b0, bus.irq};
            cap_next  = 1'b0;
        end
        da_q = bus.dataavailable;
    end

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        bus.mem_addr = a; bus.data_from_cpu = d; bus.spi_select = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.write_n = 1'b1; bus.spi_select = 1'b0;
        @(negedge clk);
        if (a == 3'd2) begin
            m_rrdy = 1'b0; m_roe = 1'b0; m_tue = 1'b0; m_abt = 1'b0;
        end
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        bus.mem_addr = a; bus.spi_select = 1'b1; bus.read_n = 1'b0;
        @(negedge clk);
        bus.read_n = 1'b1; bus.spi_select = 1'b0;
        @(negedge clk);
        d = bus.data_to_cpu;
    endtask

    task automatic write_tx(input logic [7:0] b);
        if (!m_primed) begin m_primed = 1'b1; m_hold = b; end
        else m_tue = 1'b1;
        cpu_write(3'd1, {8'h00, b});
    endtask

    task automatic read_rx();
        logic [15:0] d;
        cpu_read(3'd0, d);
        if (exp_rx.size() == 0) check("rx_underflow", d, 16'hxxxx);
        else check("rxdata", d, {8'h00, exp_rx.pop_front()});
        m_rrdy = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [15:0] d;
        cpu_read(3'd2, d);
        check(tag, d, {6'b0, 1'b0, m_roe | m_tue | m_abt, m_rrdy, ~m_primed, m_abt, m_tue, m_roe, 3'b0});
    endtask

    task automatic model_load(output logic [7:0] b);
        b = m_primed ? m_hold : FILL;
        if (!m_primed) m_tue = 1'b1;
        m_primed = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SS_n assertion of nbytes; CPU queues txq bytes and optionally drains RX at each byte start.
    task automatic spi_frame(input int nbytes, input bit rd_between);
        logic [7:0] b, got, ld;
        SS_n = 1'b0;
        model_load(ld);
        exp_miso.push_back(ld);
        wait_clk(4);
        check("miso_oe", MISO_oe, 1'b1);
        for (int k = 0; k < nbytes; k++) begin
            if (k > 0) begin
                wait_clk(4);
                if (rd_between) read_rx();
            end
            if (txq.size() > 0) write_tx(txq.pop_front());
            b = mosi_q.pop_front();
            got = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                MOSI = b[i];
                wait_clk(4);
                got = {got[6:0], MISO};
                SCLK = 1'b1;
                wait_clk(4);
                SCLK = 1'b0;
            end
            if (m_rrdy) begin m_roe = 1'b1; void'(exp_rx.pop_front()); end
            exp_rx.push_back(b);
            m_rrdy = 1'b1;
            model_load(ld);
            if (k < nbytes - 1) exp_miso.push_back(ld);
            check("miso_byte", {8'h00, got}, {8'h00, exp_miso.pop_front()});
        end
        wait_clk(4);
        SS_n = 1'b1;
        MOSI = 1'b0;
        wait_clk(6);
    endtask

    // Five SCLK edges (rise, fall, rise, fall, rise) then SS_n released mid-byte.
    task automatic spi_abort();
        logic [7:0] ld;
        SS_n = 1'b0;
        model_load(ld);
        wait_clk(4);
        for (int e = 0; e < 5; e++) begin
            SCLK = ~SCLK;
            MOSI = e[1];
            wait_clk(4);
        end
        SS_n = 1'b1;
        m_abt = 1'b1;
        wait_clk(4);
        SCLK = 1'b0;
        wait_clk(6);
    endtask

    initial begin
        logic [15:0] d;
        bus.spi_select = 1'b0; bus.mem_addr = 3'd0; bus.read_n = 1'b1; bus.write_n = 1'b1;
        bus.data_from_cpu = 16'h0000;
        wait_clk(3);
        check("reset_miso", MISO, 1'b0);
        check("reset_irq", bus.irq, 1'b0);
        reset_n = 1'b1;
        wait_clk(6);

        // Reset state
        check("miso_oe_idle", MISO_oe, 1'b0);
        check("trdy_reset", bus.readyfordata, 1'b1);
        check("rrdy_reset", bus.dataavailable, 1'b0);
        check_status("status_reset");
        cpu_read(3'd3, d); check("control_reset", d, 16'h0000);
        cpu_read(3'd0, d); check("rxdata_reset", d, 16'h0000);
        cpu_read(3'd5, d); check("reserved", d, 16'h0000);

        // Single byte with a queued TX byte
        write_tx(8'hA5);
        check("trdy_primed", bus.readyfordata, 1'b0);
        mosi_q.push_back(8'h3C);
        spi_frame(1, 1'b0);
        check("dataavailable", bus.dataavailable, 1'b1);
        check_status("status_1byte");
        read_rx();
        cpu_write(3'd2, 16'h0000);

        // Back-to-back bytes, TX refilled and RX drained between bytes
        write_tx(8'h11);
        txq.push_back(8'h22); txq.push_back(8'h33);
        mosi_q.push_back(8'hF0); mosi_q.push_back(8'h0F);
        spi_frame(2, 1'b1);
        read_rx();
        check_status("status_b2b");

        // Underrun and overrun
        mosi_q.push_back(8'hC3); mosi_q.push_back(8'h96);
        spi_frame(2, 1'b0);
        check_status("status_ovr");
        read_rx();
        cpu_write(3'd2, 16'h0000);
        check_status("status_cleared");

        // Abort mid-byte, then a clean frame
        spi_abort();
        check_status("status_abort");
        check("rrdy_after_abort", bus.dataavailable, 1'b0);
        cpu_write(3'd2, 16'h0000);
        write_tx(8'h5A);
        mosi_q.push_back(8'hA7);
        spi_frame(1, 1'b0);
        read_rx();
        cpu_write(3'd2, 16'h0000);

        // RRDY interrupt
        cpu_write(3'd3, 16'h0080);
        cpu_read(3'd3, d); check("control_rw", d, 16'h0080);
        irq_at_da = 2'b10; irq_after = 2'b10;
        mosi_q.push_back(8'h6E);
        spi_frame(1, 1'b0);
        check("irq_with_rrdy", {14'h0, irq_at_da}, 16'h0000);
        check("irq_after_rrdy", {14'h0, irq_after}, 16'h0001);
        read_rx();
        wait_clk(1);
        check("irq_cleared", bus.irq, 1'b0);
        check("rrdy_cleared", bus.dataavailable, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
